// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage sitting directly in front of a word-addressed, combinationally
//   read instruction memory. It holds the program counter and drives the memory
//   address. The returned word and its PC are captured into an IF/ID output
//   register, which hands off to decode through a valid/ready handshake.
//   A redirect (taken branch or jump) reloads the PC and flushes the output
//   register. Backpressure from decode stalls the PC.
//
// Optional feature macro: FETCH_HALT_ON_ZERO_EN
//   When this macro is defined, fetching an all-zero word stops the stage in
//   HALT and raises 'halted'. Only a redirect or a reset leaves HALT.
//   When it is undefined, zero words are issued like any other word, and
//   'halted' is tied to 0.
//
// Parameters
//   IMEM_DEPTH     : number of instruction words. Must be a power of two and
//                    at least 2. The PC wraps modulo this value.
//   RESET_PC       : word address that is loaded into the PC on reset.
//
// Ports
//   clk            : rising-edge clock
//   reset          : asynchronous, active-high reset
//   imem_addr      : word address to the memory (the current PC, upper bits zero)
//   imem_instr     : instruction word returned for imem_addr
//   redirect_valid : a branch or jump is taken; redirect_pc is sampled
//   redirect_pc    : target word address (only the low log2(IMEM_DEPTH) bits are used)
//   id_valid       : id_instr and id_pc hold an instruction for decode
//   id_ready       : decode accepts the output register this cycle
//   id_instr       : registered instruction word
//   id_pc          : registered word address of id_instr
//   halted         : fetch has stopped on a zero word (feature builds only)

module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam logic [31:0] RESET_PC_FULL = RESET_PC;
  localparam logic [AW-1:0] RESET_PC_W = RESET_PC_FULL[AW-1:0];

  logic [AW-1:0] pc_q, pc_d;
  logic          id_valid_q, id_valid_d;
  logic [31:0]   id_instr_q, id_instr_d;
  logic [AW-1:0] id_pc_q, id_pc_d;
  logic          advance;

  // The upper redirect bits are discarded by the modulo-depth PC.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[31:AW];

  // Advance when the output register is empty or is being consumed this cycle.
  assign advance = !id_valid_q || id_ready;

  assign imem_addr = {{(32-AW){1'b0}}, pc_q};
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = {{(32-AW){1'b0}}, id_pc_q};

`ifdef FETCH_HALT_ON_ZERO_EN

  typedef enum logic {RUN, HALT} state_t;

  state_t state_q, state_d;
  logic   halted_q, halted_d;

  assign halted = halted_q;

  // A redirect wins over everything and flushes the output register.
  // In RUN, a zero word parks the stage in HALT without issuing that word.
  // In HALT, the output register is only drained.
  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    state_d    = state_q;
    halted_d   = halted_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc[AW-1:0];
      id_valid_d = 1'b0;
      state_d    = RUN;
      halted_d   = 1'b0;
    end else if (state_q == RUN && advance) begin
      if (imem_instr == 32'h0) begin
        id_valid_d = 1'b0;
        state_d    = HALT;
        halted_d   = 1'b1;
      end else begin
        id_instr_d = imem_instr;
        id_pc_d    = pc_q;
        id_valid_d = 1'b1;
        pc_d       = pc_q + 1'b1;
      end
    end else if (advance) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC_W;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
      id_pc_q    <= '0;
      state_q    <= RUN;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      state_q    <= state_d;
      halted_q   <= halted_d;
    end
  end

`else

  assign halted = 1'b0;

  // A redirect wins over everything and flushes the output register.
  // Otherwise, load a new word whenever the output register can advance.
  // The PC wraps naturally at IMEM_DEPTH because it is exactly AW bits wide.
  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc[AW-1:0];
      id_valid_d = 1'b0;
    end else if (advance) begin
      id_instr_d = imem_instr;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
      pc_d       = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC_W;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
      id_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit in the default build (halt-on-zero disabled).
// A behavioural model tracks the expected PC and the contents of the output
// register, working from the fetch rules.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;

  logic [31:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int unsigned m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int unsigned m_out_pc;

  instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign imem_instr = mem[imem_addr[5:0]];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_pc     = 0;
    m_valid  = 0;
    m_instr  = 32'h0;
    m_out_pc = 0;
  endtask

  // Compare the DUT against the model. The register contents are checked
  // only while the model says they are valid.
  task automatic checkOutput(input string tag);
    check32({tag, ":imem_addr"}, imem_addr, 32'(m_pc));
    check32({tag, ":id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
    check32({tag, ":halted"}, {31'b0, halted}, 32'h0);
    if (m_valid) begin
      check32({tag, ":id_pc"}, id_pc, 32'(m_out_pc));
      check32({tag, ":id_instr"}, id_instr, m_instr);
    end
  endtask

  // Drive one cycle of inputs (starting from a negedge), update the model at
  // the rising edge, and then check at the following negedge.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit rdy, input string tag);
    bit adv;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(posedge clk);
    adv = !m_valid || rdy;
    if (redir) begin
      m_pc    = rpc % DEPTH;
      m_valid = 0;
    end else if (adv) begin
      m_instr  = mem[m_pc];
      m_out_pc = m_pc;
      m_valid  = 1;
      m_pc     = (m_pc + 1) % DEPTH;
    end
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom | 32'h1;
    mem[16] = 32'h0;

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    check32("rst:id_valid", {31'b0, id_valid}, 32'h0);
    check32("rst:id_pc", id_pc, 32'h0);
    check32("rst:id_instr", id_instr, 32'h0);
    check32("rst:halted", {31'b0, halted}, 32'h0);
    check32("rst:imem_addr", imem_addr, 32'h0);
    reset = 1'b0;

    // Stream from RESET_PC. The zero word at 16 is issued normally.
    $display("[TB] streaming");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b1, "stream");
    check32("stream:zero_word_issued", id_pc, 32'd19);

    // Stall while the output register holds pc 5.
    applyStimulus(1'b1, 32'd0, 1'b1, "redir0");
    for (int i = 0; i < 10 && !(m_valid && m_out_pc == 5); i++)
      applyStimulus(1'b0, 32'h0, 1'b1, "to5");
    check32("stall:at5", id_pc, 32'd5);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, "stall");
    check32("stall:pc_held", imem_addr, 32'd6);
    check32("stall:instr_held", id_instr, mem[5]);
    applyStimulus(1'b0, 32'h0, 1'b1, "release6");
    check32("release:pc6", id_pc, 32'd6);
    applyStimulus(1'b0, 32'h0, 1'b1, "release7");
    check32("release:pc7", id_pc, 32'd7);

    // Redirect during a stall flushes the output register.
    for (int i = 0; i < 10 && !(m_valid && m_out_pc == 9); i++)
      applyStimulus(1'b0, 32'h0, 1'b1, "to9");
    applyStimulus(1'b0, 32'h0, 1'b0, "hold9");
    applyStimulus(1'b1, 32'd2, 1'b0, "redir_stall");
    check32("redir:flushed", {31'b0, id_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, "redir_target");
    check32("redir:target_pc", id_pc, 32'd2);
    check32("redir:target_instr", id_instr, mem[2]);

    // Wrap-around from 62, then an out-of-range target.
    applyStimulus(1'b1, 32'd62, 1'b1, "redir62");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, "wrap");
    check32("wrap:id_pc", id_pc, 32'd1);
    applyStimulus(1'b1, 32'd70, 1'b1, "redir70");
    check32("redir70:imem_addr", imem_addr, 32'd6);

    // Asynchronous reset in the middle of the stream at pc 7.
    applyStimulus(1'b1, 32'd0, 1'b1, "redir0b");
    for (int i = 0; i < 10 && !(m_valid && m_out_pc == 7); i++)
      applyStimulus(1'b0, 32'h0, 1'b1, "to7");
    check32("async:at7", id_pc, 32'd7);
    #2 reset = 1'b1;
    #1;
    check32("async:id_valid", {31'b0, id_valid}, 32'h0);
    check32("async:id_pc", id_pc, 32'h0);
    check32("async:id_instr", id_instr, 32'h0);
    check32("async:halted", {31'b0, halted}, 32'h0);
    resetModel();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, "restart");
    check32("restart:pc2", id_pc, 32'd2);

    // Randomized stimulus.
    $display("[TB] random");
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom % 8) == 0, 32'($urandom_range(0, 127)), ($urandom % 3) != 0, "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
